// File: rtl/sine_sweep_ctrl_if.sv
// Control/status bundle between the register block (master) and the sweep
// sequencer (slave), including the frequency word fed to the sine generator.
interface sine_sweep_ctrl_if #(
  parameter int DW = 12,
  parameter int CW = 16
);
  logic          start;
  logic          abort;
  logic          mode;
  logic [DW-1:0] f_start;
  logic [DW-1:0] f_stop;
  logic [DW-1:0] f_step;
  logic [CW-1:0] dwell;
  logic [DW-1:0] delta;
  logic          phase_clr;
  logic          busy;
  logic          done;
  logic          wrap;

  modport master (
    output start, abort, mode, f_start, f_stop, f_step, dwell,
    input  delta, phase_clr, busy, done, wrap
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_step, dwell,
    output delta, phase_clr, busy, done, wrap
  );
endinterface

// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the generator's delta word from f_start to
// f_stop, holding each value dwell+1 cycles, in single-shot or sawtooth mode.
module sine_sweep_ctrl #(
  parameter int DW = 12,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  sine_sweep_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [DW-1:0] delta_q, delta_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_q, busy_n;
  logic          phase_clr_q, phase_clr_n;
  logic          done_q, done_n;
  logic          wrap_q, wrap_n;
  logic          load;

  // Configuration captured at start acceptance; inputs are ignored during RUN.
  logic [DW-1:0] sh_start, sh_stop, sh_step;
  logic [CW-1:0] sh_dwell;
  logic          sh_mode;
  logic          sh_up;

  logic [DW:0]   sum, diff;
  logic [DW-1:0] next_val;
  logic          end_pt;

  // Extra MSB catches carry/borrow so the sweep clamps to stop instead of
  // wrapping through 0 or 2^DW.
  always_comb begin
    sum  = {1'b0, delta_q} + {1'b0, sh_step};
    diff = {1'b0, delta_q} - {1'b0, sh_step};
    if (sh_up)
      next_val = (sum[DW] || (sum[DW-1:0] > sh_stop)) ? sh_stop : sum[DW-1:0];
    else
      next_val = (diff[DW] || (diff[DW-1:0] < sh_stop)) ? sh_stop : diff[DW-1:0];
    end_pt = (delta_q == sh_stop) || (sh_step == '0);
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_n     = state;
    delta_n     = delta_q;
    cnt_n       = cnt;
    busy_n      = busy_q;
    phase_clr_n = 1'b0;
    done_n      = 1'b0;
    wrap_n      = 1'b0;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_n     = RUN;
          load        = 1'b1;
          delta_n     = bus.f_start;
          cnt_n       = bus.dwell;
          busy_n      = 1'b1;
          phase_clr_n = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_n = IDLE;
          delta_n = '0;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (end_pt) begin
          if (!sh_mode) begin
            state_n = IDLE;
            delta_n = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            delta_n = sh_start;
            cnt_n   = sh_dwell;
            wrap_n  = 1'b1;
          end
        end else begin
          delta_n = next_val;
          cnt_n   = sh_dwell;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the shadow registers are reset too, so a post-reset sweep can never
  // run on stale configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      delta_q     <= '0;
      cnt         <= '0;
      busy_q      <= 1'b0;
      phase_clr_q <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      sh_start    <= '0;
      sh_stop     <= '0;
      sh_step     <= '0;
      sh_dwell    <= '0;
      sh_mode     <= 1'b0;
      sh_up       <= 1'b0;
    end else begin
      state       <= state_n;
      delta_q     <= delta_n;
      cnt         <= cnt_n;
      busy_q      <= busy_n;
      phase_clr_q <= phase_clr_n;
      done_q      <= done_n;
      wrap_q      <= wrap_n;
      if (load) begin
        sh_start <= bus.f_start;
        sh_stop  <= bus.f_stop;
        sh_step  <= bus.f_step;
        sh_dwell <= bus.dwell;
        sh_mode  <= bus.mode;
        sh_up    <= (bus.f_stop >= bus.f_start);
      end
    end
  end

  assign bus.delta     = delta_q;
  assign bus.phase_clr = phase_clr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: doc/sine_sweep_ctrl.md
# sine_sweep_ctrl

Frequency-sweep sequencer for the phase-accumulator sine generator. It steps the generator's 12-bit frequency word `delta` from a start value to a stop value in fixed increments. Each value is held for a programmable dwell time. It supports single-shot and continuous (sawtooth) sweeps, with start/abort control and busy/done status. It sits between the register/control interface and the sine generator, whose `delta` input it drives directly.

## Interface
- `DW`, 12: width of frequency word and config values.
- `CW`, 16: width of dwell counter.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `abort`  in  1  terminate sweep immediately; highest priority.
- `mode`  in  1  0 = single sweep, 1 = continuous.
- `f_start`  in  DW  first frequency word.
- `f_stop`  in  DW  last frequency word.
- `f_step`  in  DW  increment magnitude, unsigned.
- `dwell`  in  CW  hold count; each value is held `dwell`+1 cycles.
- `delta`  out  DW  frequency word to the generator; registered.
- `phase_clr`  out  1  one-cycle pulse to clear the generator's phase accumulator.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse at the end of a single sweep.
- `wrap`  out  1  one-cycle pulse when a continuous sweep restarts at `f_start`.

## Operation
- **States.** The FSM has two states: IDLE and RUN.
- **Config latch.** At start acceptance, `f_start`, `f_stop`, `f_step`, `dwell` and `mode` are latched into shadow registers. Input changes during RUN are ignored.
- **Direction.** up if `f_stop` >= `f_start`, else down. Direction is fixed for the whole sweep.
- **IDLE + start (no abort).** Go to RUN and register:
  - `delta` <= `f_start`
  - `phase_clr` <= 1
  - `busy` <= 1
  - `cnt` <= `dwell`
- **RUN, `cnt` != 0.** `cnt` decrements; `delta` holds.
- **RUN, `cnt` == 0, end point reached.** The end point is reached when `delta` == stop or `f_step` == 0.
  - Single mode: go to IDLE; `delta` <= 0, `busy` <= 0, `done` <= 1.
  - Continuous mode: `delta` <= start, `cnt` <= dwell, `wrap` <= 1. No `phase_clr`.
- **RUN, `cnt` == 0, otherwise.** `delta` <= next value, `cnt` <= dwell.
- **Next value.** Computed at DW+1 bits.
  - up: sum = `delta` + step; if carry or sum > stop, next = stop.
  - down: diff = `delta` - step; if borrow or diff < stop, next = stop.
  - The stop value is therefore always emitted exactly, and the sweep never wraps through 0 or 2^DW.
- **Point count.** K = ceil(|stop − start| / step) + 1, with K = 1 when step = 0 or start = stop. A single sweep keeps `busy` high for K·(`dwell`+1) cycles.
- **Abort.** `abort` in RUN forces IDLE next cycle: `delta` <= 0, `busy` <= 0, `cnt` <= 0, no `done` and no `wrap`. Abort in IDLE has no effect.
- **Start/abort conflicts.** `start` while `busy` is ignored, with no queuing. `start` together with `abort` in IDLE is rejected: the block stays in IDLE.
- **Pulse outputs.** `phase_clr`, `done` and `wrap` default to 0 each cycle and are mutually exclusive.
- **Reset.** `rst` asserted at any time, including mid-sweep, asynchronously clears:
  - state to IDLE
  - `delta`, `cnt` and shadow registers to 0
  - `phase_clr`, `busy`, `done`, `wrap` to 0

## Timing
- Start is sampled at edge E. From E:
  - `delta` = `f_start` and `busy` = 1.
  - `phase_clr` = 1 for exactly one cycle, coincident with the first `delta` value.
- Each frequency value is visible for exactly `dwell`+1 consecutive cycles.
- The last value is followed directly by `delta` = 0 with `done` = 1 and `busy` = 0 in the same cycle.
- A new start is accepted in the cycle after `done`. The minimum gap is one IDLE cycle.
- In continuous mode the last value is followed directly by `f_start` with `wrap` = 1. There is no idle gap.
- Abort latency: one edge.

## Test plan
- **Reset.** Hold `rst` = 1, toggle all inputs -> `delta` = 0, `busy`/`done`/`wrap`/`phase_clr` = 0. Release, then start -> sweep begins normally.
- **Single up sweep.** start = 100, stop = 130, step = 10, dwell = 2, mode = 0.
  - `delta` = 100,100,100,110×3,120×3,130×3.
  - `phase_clr` high only in the first cycle; `busy` high 12 cycles.
  - Then `delta` = 0 with a single `done` pulse.
- **Clamping.**
  - Up: start = 0xF00, stop = 0xFFF, step = 0x80, dwell = 0 -> 0xF00, 0xF80, 0xFFF, done.
  - Down: start = 0xFF0, stop = 0xF00, step = 0x60 -> 0xFF0, 0xF90, 0xF30, 0xF00, done.
- **Continuous.** start = 10, stop = 20, step = 5, dwell = 0, mode = 1.
  - `delta` = 10,15,20,10,15,20,…
  - `wrap` pulses on each return to 10; no `done`; `phase_clr` only at initial start.
- **Control conflicts.**
  - `start` pulsed mid-sweep -> ignored, sequence unchanged.
  - `abort` mid-sweep -> next cycle `delta` = 0, `busy` = 0, no `done`.
  - `start` + `abort` same cycle in IDLE -> stays idle.
  - Config inputs changed mid-sweep -> no effect.
- **Degenerate cases and reset mid-sweep.**
  - step = 0 (or start = stop = 42), dwell = 3 -> `delta` = 42 for 4 cycles, then `done`.
  - `rst` pulsed mid-sweep -> immediate return to reset values.
